chromosome_mutator: RTL

Mutation stage of the genetic pipeline, directly downstream of the cellular-automaton random generator. It accepts one chromosome over a valid/ready handshake and drives the generator's `ce` for a fixed number of attempts. Each attempt consumes one random word, which may flip one chromosome bit. The mutated chromosome is then offered downstream over a second valid/ready handshake.

---
 rtl/chromosome_mutator.sv | 110 +++++++++++
 1 files changed

// File: rtl/chromosome_mutator.sv
// Mutation stage: consumes Attempts random words per chromosome, each possibly flipping one bit.
// Optional MUTATOR_COUNT_EN adds a mutation_count output tallying performed flips.
module chromosome_mutator #(
    parameter int Width      = 8,
    parameter int IndexWidth = 4,
    parameter int Attempts   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2**IndexWidth-1:0]      in_chromosome,
    input  logic [Width-IndexWidth-1:0]   rate,
    input  logic [Width-1:0]              random,
    output logic                          random_ce,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef MUTATOR_COUNT_EN
    output logic [7:0]                    mutation_count,
`endif
    output logic [2**IndexWidth-1:0]      out_chromosome
);

    localparam int ChromWidth = 2**IndexWidth;

    typedef enum logic [1:0] {IDLE, MUTATE, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [7:0]              attempt_reg;
    logic [ChromWidth-1:0]   chrom_reg;
    logic [IndexWidth-1:0]   index;
    logic [Width-IndexWidth-1:0] draw;
    logic                    flip;
    logic                    last_attempt;
    logic [ChromWidth-1:0]   flip_mask;

    assign index        = random[IndexWidth-1:0];
    assign draw         = random[Width-1:IndexWidth];
    assign flip         = (state_reg == MUTATE) && (draw < rate);
    assign last_attempt = (attempt_reg == 8'(Attempts - 1));

    // One-hot mask of the bit selected by this attempt, empty when no flip.
    generate
        for (genvar gi = 0; gi < ChromWidth; gi++) begin : g_mask
            assign flip_mask[gi] = flip && (index == IndexWidth'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        random_ce  = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = MUTATE;
            end
            MUTATE: begin
                random_ce = 1'b1;
                if (last_attempt) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            attempt_reg <= 8'd0;
            chrom_reg   <= '0;
        end else if (state_reg == IDLE && in_valid) begin
            attempt_reg <= 8'd0;
            chrom_reg   <= in_chromosome;
        end else if (state_reg == MUTATE) begin
            attempt_reg <= attempt_reg + 8'd1;
            chrom_reg   <= chrom_reg ^ flip_mask;
        end
    end

    assign out_chromosome = chrom_reg;

`ifdef MUTATOR_COUNT_EN
    logic [7:0] mutation_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mutation_count_reg <= 8'd0;
        end else if (state_reg == IDLE && in_valid) begin
            mutation_count_reg <= 8'd0;
        end else if (flip) begin
            mutation_count_reg <= mutation_count_reg + 8'd1;
        end
    end

    assign mutation_count = mutation_count_reg;
`endif

endmodule
